uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the sticky parity_err output.
module uart_rx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_bit,
    input  logic [7:0] freq_divider,
    input  logic       pop,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic [2:0] dbg_state_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3,
                              STOP = 3'd4, WAIT_HIGH = 3'd5} state_e;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2,
                              STOP = 3'd4, WAIT_HIGH = 3'd5} state_e;
`endif

    logic         sync1_q, sync2_q;
    logic [7:0]   presc_q, div_q;
    logic         tick;
    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    logic [7:0]   data_q, data_d;
    logic         push_req, frame_set;
    logic         frame_err_q, overrun_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]  count_q;
    logic [7:0]   mem_q [FIFO_DEPTH];
    logic         do_push, do_pop, is_full;
`ifdef UART_RX_PARITY_EN
    logic         par_bad_q, par_bad_d, parity_set, parity_err_q;
`endif

    // The divider is latched at each reload so a mid-count change cannot overshoot.
    assign tick = (presc_q == div_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            presc_q <= 8'd0;
            div_q   <= 8'd0;
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
        end else begin
            sync1_q <= rx_bit;
            sync2_q <= sync1_q;
            presc_q <= tick ? 8'd0 : presc_q + 8'd1;
            if (tick) div_q <= freq_divider;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                IDLE: if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = 4'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
                // Mid-start-bit check: a high line here was a glitch.
                START: if (cnt_q == 4'd7) begin
                    if (!sync2_q) begin
                        state_d = DATA;
                        cnt_d   = 4'd0;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                DATA: if (cnt_q == 4'd15) begin
                    data_d[idx_q] = sync2_q;
                    cnt_d = 4'd0;
                    idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    state_d = STOP;
                    if (sync2_q != ^data_q) begin
                        parity_set = 1'b1;
                        par_bad_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
                STOP: if (cnt_q == 4'd15) begin
                    cnt_d = 4'd0;
                    if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
                        push_req = !par_bad_q;
`else
                        push_req = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                WAIT_HIGH: if (sync2_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign is_full = (count_q == FULL_CNT);
    assign do_pop  = pop && (count_q != '0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = push_req && (!is_full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
            frame_err_q <= (frame_err_q && !clr_err) || frame_set;
            overrun_q   <= (overrun_q && !clr_err) || (push_req && !do_push);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_q;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= (parity_err_q && !clr_err) || parity_set;
        end
    end
    assign parity_err = parity_err_q;
`endif

    assign empty       = (count_q == '0);
    assign full        = is_full;
    assign data_out    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule
